// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel divisor/high time with
// period-boundary reload, enable gating, rise/wrap strobes and a shared phase sync.
module clock_divider_multi #(
  parameter int NUM_CHANNELS = 2,
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_DIV  = 2,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] en,
  input  logic                    sync,
  input  logic                    cfg_wr,
  input  logic [CW-1:0]           cfg_chan,
  input  logic [DIV_WIDTH-1:0]    cfg_div,
  input  logic [DIV_WIDTH-1:0]    cfg_high,
  output logic [NUM_CHANNELS-1:0] clkout,
  output logic [NUM_CHANNELS-1:0] rise,
  output logic [NUM_CHANNELS-1:0] wrap
);

  localparam int DIV_MAX   = (1 << DIV_WIDTH) - 1;
  localparam int DEF_CLAMP = (DEFAULT_DIV < 2) ? 2 :
                             (DEFAULT_DIV > DIV_MAX) ? DIV_MAX : DEFAULT_DIV;
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEF_CLAMP);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt    [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] div_a  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] high_a [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] div_p  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] high_p [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] last   [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] h_eff  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] thr    [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] wr_div;
  logic [NUM_CHANNELS-1:0] hit;
  logic [NUM_CHANNELS-1:0] load;

  always_comb begin
    wr_div = (cfg_div < TWO) ? TWO : cfg_div;
    hit    = '0;
    load   = '0;
    clkout = '0;
    rise   = '0;
    wrap   = '0;
    last   = '{default: '0};
    h_eff  = '{default: '0};
    thr    = '{default: '0};
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      // Out-of-range channel numbers never match any index, so they are dropped.
      hit[i]  = cfg_wr && (32'(cfg_chan) == i);
      last[i] = div_a[i] - ONE;
      if (high_a[i] == '0)
        h_eff[i] = div_a[i] >> 1;
      else if (high_a[i] > last[i])
        h_eff[i] = last[i];
      else
        h_eff[i] = high_a[i];
      thr[i]    = div_a[i] - h_eff[i];
      clkout[i] = en[i] && (cnt[i] >= thr[i]);
      rise[i]   = en[i] && (cnt[i] == thr[i]);
      wrap[i]   = en[i] && (cnt[i] == last[i]);
      load[i]   = !en[i] || sync || wrap[i];
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        cnt[i]    <= '0;
        div_a[i]  <= DEF;
        div_p[i]  <= DEF;
        high_a[i] <= '0;
        high_p[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (hit[i]) begin
          div_p[i]  <= wr_div;
          high_p[i] <= cfg_high;
        end
        // A write landing on a reload cycle bypasses pending so it is active next cycle.
        if (load[i]) begin
          cnt[i]    <= '0;
          div_a[i]  <= hit[i] ? wr_div : div_p[i];
          high_a[i] <= hit[i] ? cfg_high : high_p[i];
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: per-cycle comparison of all output
// vectors against hand-computed bit patterns (bit k = k-th sampled cycle).
module tb_clock_divider_multi;

  logic       clkin;
  logic       reset;
  logic [2:0] en;
  logic       sync;
  logic       cfg_wr;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic [2:0] clkout;
  logic [2:0] rise;
  logic [2:0] wrap;

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(
    .NUM_CHANNELS(3),
    .DIV_WIDTH(8),
    .DEFAULT_DIV(2)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .en(en),
    .sync(sync),
    .cfg_wr(cfg_wr),
    .cfg_chan(cfg_chan),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .clkout(clkout),
    .rise(rise),
    .wrap(wrap)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check(input string tag, input string sig, input int k,
                       input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s cycle %0d observed=%b expected=%b", tag, sig, k, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; samples n cycles, returns at posedge+1.
  // Channel 2 is never enabled, so its outputs are always expected low.
  task automatic run(input string tag, input int n,
                     input logic [15:0] c0, input logic [15:0] r0, input logic [15:0] w0,
                     input logic [15:0] c1, input logic [15:0] r1, input logic [15:0] w1);
    for (int k = 0; k < n; k++) begin
      #1;
      check(tag, "clkout", k, clkout, {1'b0, c1[k], c0[k]});
      check(tag, "rise",   k, rise,   {1'b0, r1[k], r0[k]});
      check(tag, "wrap",   k, wrap,   {1'b0, w1[k], w0[k]});
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] hi);
    cfg_wr   = 1'b1;
    cfg_chan = ch;
    cfg_div  = dv;
    cfg_high = hi;
  endtask

  initial begin
    reset = 1'b1; en = '0; sync = 1'b0;
    cfg_wr = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_high = '0;
    repeat (3) @(posedge clkin);
    #1;
    run("reset_hold", 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    run("reset_idle", 2, 0, 0, 0, 0, 0, 0);

    // Default divisor 2: 0,1,0,1...; ch1 stays off.
    en = 3'b001;
    run("default_div2", 7, 16'h2A, 16'h2A, 16'h2A, 0, 0, 0);

    // ch0 at cnt=1 (would be high): disabling gates it low the same cycle.
    en = 3'b000; write(2'd0, 8'd5, 8'd0);
    run("disable_gate", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0;
    run("disabled_idle", 1, 0, 0, 0, 0, 0, 0);
    en = 3'b001;
    run("div5", 10, 16'h318, 16'h108, 16'h210, 0, 0, 0);

    // Running div=4; write div=6 high=1 at cnt=1 finishes old period first.
    en = 3'b000; write(2'd0, 8'd4, 8'd0);
    run("div4_setup", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0;
    run("div4_idle", 1, 0, 0, 0, 0, 0, 0);
    en = 3'b001;
    run("div4_cnt0", 1, 0, 0, 0, 0, 0, 0);
    write(2'd0, 8'd6, 8'd1);
    run("div4_cnt1_wr", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0;
    run("glitchfree_div6", 14, 16'h2083, 16'h2081, 16'h2082, 0, 0, 0);

    // Clamp: div=1 behaves as div=2.
    en = 3'b000; write(2'd0, 8'd1, 8'd0);
    run("clamp1_setup", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0;
    run("clamp1_idle", 1, 0, 0, 0, 0, 0, 0);
    en = 3'b001;
    run("clamp_div1", 4, 16'hA, 16'hA, 16'hA, 0, 0, 0);

    // Clamp: div=4 high=9 -> h=3, pattern 0,1,1,1.
    en = 3'b000; write(2'd0, 8'd4, 8'd9);
    run("clamp_hi_setup", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0;
    run("clamp_hi_idle", 1, 0, 0, 0, 0, 0, 0);
    en = 3'b001;
    run("clamp_high", 8, 16'hEE, 16'h22, 16'h88, 0, 0, 0);

    // Write to channel 3 (nonexistent) must not disturb ch0.
    write(2'd3, 8'd2, 8'd0);
    run("bad_chan_wr", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0;
    run("bad_chan_after", 7, 16'h77, 16'h11, 16'h44, 0, 0, 0);

    // Sync with a simultaneous write-through to ch0 (div 4 -> 3); ch1 div=6.
    en = 3'b000; write(2'd0, 8'd4, 8'd0);
    run("sync_setup0", 1, 0, 0, 0, 0, 0, 0);
    write(2'd1, 8'd6, 8'd0);
    run("sync_setup1", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0; en = 3'b001;
    run("sync_e0", 1, 0, 0, 0, 0, 0, 0);
    en = 3'b011; sync = 1'b1; write(2'd0, 8'd3, 8'd0);
    run("sync_pulse", 1, 0, 0, 0, 0, 0, 0);
    sync = 1'b0; cfg_wr = 1'b0;
    run("sync_aligned", 12, 16'h924, 16'h924, 16'h924, 16'hE38, 16'h208, 16'h820);

    // Pending write to ch1, then reset mid-period discards it.
    write(2'd1, 8'd4, 8'd0);
    run("rst_pending_wr", 1, 0, 0, 0, 0, 0, 0);
    cfg_wr = 1'b0;
    run("rst_pre", 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    run("rst_cycle", 1, 16'h1, 16'h1, 16'h1, 0, 0, 0);
    reset = 1'b0;
    run("post_reset", 6, 16'h2A, 16'h2A, 16'h2A, 16'h2A, 16'h2A, 16'h2A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
